score_tracker: RTL and testbench



---
 rtl/score_pkg.sv | 12 +
 rtl/score_tracker_point_qualifier.sv | 54 +++++
 rtl/score_tracker.sv | 137 +++++++++++++
 tb/tb_score_tracker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared constants for the score tracker: FSM encodings, score bus width
// and the default saturation ceiling.
package score_pkg;

  localparam int SCORE_W       = 10;
  localparam int MAX_SCORE_DEF = 99;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

endpackage

// File: rtl/score_tracker_point_qualifier.sv
// Point-edge qualifier: registers point_evt for rise detection and runs the
// post-count holdoff window. A rise only qualifies while enabled and with no
// holdoff pending; rises during holdoff are simply lost.
module point_qualifier
  import score_pkg::*;
#(
  parameter int HOLDOFF = 8,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic point_evt,
  input  logic enable,
  input  logic count_ack,
  output logic qualified
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] HOLD_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);

  logic             evt_q;
  logic             evt_d;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;
  logic             rise_s;

  // Rise detect and qualification; holdoff reloads on every counted point
  // (including saturated ones) and otherwise drains toward zero in any state.
  always_comb begin
    evt_d     = point_evt;
    rise_s    = point_evt & ~evt_q;
    qualified = rise_s & enable & (hold_q == HOLD_ZERO);
    if (count_ack) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != HOLD_ZERO) begin
      hold_d = hold_q - HOLD_ONE;
    end else begin
      hold_d = hold_q;
    end
  end

  // Edge register and holdoff counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q  <= 1'b0;
      hold_q <= HOLD_ZERO;
    end else begin
      evt_q  <= evt_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Game score tracker: IDLE/PLAY/OVER phase FSM, saturating point counter and
// session high score. Feeds the two-digit glyph decoder through `score`.
module score_tracker
  import score_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEF,
  parameter int HOLDOFF   = 8,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_start,
  input  logic               game_over,
  input  logic               point_evt,
  input  logic               clear_high,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic               score_pulse,
  output logic [1:0]         state
);

  localparam logic [SCORE_W-1:0] MAX_S  = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] ZERO_S = {SCORE_W{1'b0}};
  localparam logic [SCORE_W-1:0] ONE_S  = SCORE_W'(1);

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic               new_high_q, new_high_d;
  logic               pulse_q, pulse_d;

  logic               qual_en_s;
  logic               qualified_s;

  // Points are only eligible in PLAY and never in the game_over cycle, so the
  // commit always sees the pre-point score.
  always_comb begin
    qual_en_s = (state_q == ST_PLAY) & ~game_over;
  end

  point_qualifier #(
    .HOLDOFF (HOLDOFF),
    .CNT_W   (CNT_W)
  ) u_qual (
    .clk       (clk),
    .rst_n     (rst_n),
    .point_evt (point_evt),
    .enable    (qual_en_s),
    .count_ack (qualified_s),
    .qualified (qualified_s)
  );

  // Phase transitions, scoring and high-score commit; clear_high overrides
  // the high-score value last so it wins over a same-cycle commit.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    pulse_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (game_start) begin
          state_d = ST_PLAY;
          score_d = ZERO_S;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (game_over) begin
          state_d = ST_OVER;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end else begin
            new_high_d = 1'b0;
          end
        end else if (qualified_s) begin
          if (score_q < MAX_S) begin
            score_d = score_q + ONE_S;
            pulse_d = 1'b1;
          end else begin
            score_d = score_q;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (game_start) begin
          state_d    = ST_PLAY;
          score_d    = ZERO_S;
          new_high_d = 1'b0;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (clear_high) begin
      high_d = ZERO_S;
    end else begin
      high_d = high_d;
    end
  end

  // State, score, high score and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      score_q    <= ZERO_S;
      high_q     <= ZERO_S;
      new_high_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      pulse_q    <= pulse_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    score       = score_q;
    high_score  = high_q;
    new_high    = new_high_q;
    score_pulse = pulse_q;
    state       = state_q;
  end

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: a timestamp-based game model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_score_tracker;

  localparam int HOLDOFF = 8;
  localparam int MAXS    = 99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_start = 1'b0;
  logic       game_over = 1'b0;
  logic       point_evt = 1'b0;
  logic       clear_high = 1'b0;
  logic [9:0] score;
  logic [9:0] high_score;
  logic       new_high;
  logic       score_pulse;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  int dut_pulses = 0;
  int p0;

  // model: phase 0 idle, 1 play, 2 over; holdoff via timestamp of last count
  int m_state = 0, m_score = 0, m_high = 0, m_nh = 0, m_pulse = 0;
  int m_prev = 0, m_last = -1000, cyc = 0;

  score_tracker #(.MAX_SCORE(MAXS), .HOLDOFF(HOLDOFF), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_start  (game_start),
    .game_over   (game_over),
    .point_evt   (point_evt),
    .clear_high  (clear_high),
    .score       (score),
    .high_score  (high_score),
    .new_high    (new_high),
    .score_pulse (score_pulse),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_nh = 0; m_pulse = 0;
    m_prev = 0; m_last = -1000;
  endtask

  task automatic model_step();
    bit rise;
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      rise = point_evt && !m_prev;
      m_prev = point_evt;
      m_pulse = 0;
      if (m_state == 0) begin
        if (game_start) begin m_state = 1; m_score = 0; end
      end else if (m_state == 1) begin
        if (game_over) begin
          m_state = 2;
          if (m_score > m_high) begin m_high = m_score; m_nh = 1; end
          else m_nh = 0;
        end else if (rise && (cyc - m_last > HOLDOFF)) begin
          m_last = cyc;
          if (m_score < MAXS) begin m_score++; m_pulse = 1; end
        end
      end else begin
        if (game_start) begin m_state = 1; m_score = 0; m_nh = 0; end
      end
      if (clear_high) m_high = 0;
    end
  endtask

  // model advance on each active edge
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // per-cycle comparison on the opposite edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("state", 32'(state), 32'(m_state));
      check("score", 32'(score), 32'(m_score));
      check("high_score", 32'(high_score), 32'(m_high));
      check("new_high", 32'(new_high), 32'(m_nh));
      check("score_pulse", 32'(score_pulse), 32'(m_pulse));
      if (score_pulse === 1'b1) dut_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_game();
    game_start = 1'b1; tick(); game_start = 1'b0;
  endtask

  task automatic end_game();
    game_over = 1'b1; tick(); game_over = 1'b0;
  endtask

  task automatic add_point();
    point_evt = 1'b1; tick(); point_evt = 1'b0;
    repeat (9) tick();
  endtask

  task automatic play_game(input int n);
    start_game();
    repeat (n) add_point();
    end_game();
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_state", 32'(state), 32'd0);
    check("reset_score", 32'(score), 32'd0);
    game_over = 1'b1; tick(); game_over = 1'b0;
    check("over_in_idle", 32'(state), 32'd0);

    // holdoff and latency
    start_game();
    check("enter_play", 32'(state), 32'd1);
    p0 = dut_pulses;
    point_evt = 1'b1; tick(); point_evt = 1'b0;
    check("latency_score", 32'(score), 32'd1);
    check("latency_pulse", 32'(score_pulse), 32'd1);
    tick(); tick();
    point_evt = 1'b1; tick(); point_evt = 1'b0;
    check("holdoff_drop", 32'(score), 32'd1);
    repeat (6) tick();
    point_evt = 1'b1; tick(); point_evt = 1'b0;
    check("holdoff_resume", 32'(score), 32'd2);
    check("holdoff_pulse", 32'(score_pulse), 32'd1);
    tick();
    check("holdoff_pulse_count", 32'(dut_pulses - p0), 32'd2);

    // held level scores once
    repeat (10) tick();
    point_evt = 1'b1; repeat (50) tick(); point_evt = 1'b0;
    tick();
    check("held_level", 32'(score), 32'd3);

    // game_start ignored in PLAY
    start_game();
    check("start_in_play", 32'(state), 32'd1);
    check("start_in_play_score", 32'(score), 32'd3);

    // point rise together with game_over
    repeat (10) tick();
    point_evt = 1'b1; game_over = 1'b1; tick();
    point_evt = 1'b0; game_over = 1'b0;
    check("collide_state", 32'(state), 32'd2);
    check("collide_score", 32'(score), 32'd3);
    check("collide_high", 32'(high_score), 32'd3);
    check("collide_nh", 32'(new_high), 32'd1);
    end_game();
    check("over_in_over", 32'(state), 32'd2);

    // clear_high on the commit cycle of a 4-point game
    start_game();
    repeat (4) add_point();
    game_over = 1'b1; clear_high = 1'b1; tick();
    game_over = 1'b0; clear_high = 1'b0;
    check("clear_commit_high", 32'(high_score), 32'd0);
    check("clear_commit_nh", 32'(new_high), 32'd1);

    // record sequence
    play_game(5);
    check("gameA_high", 32'(high_score), 32'd5);
    check("gameA_nh", 32'(new_high), 32'd1);
    play_game(5);
    check("gameB_high", 32'(high_score), 32'd5);
    check("gameB_nh", 32'(new_high), 32'd0);
    play_game(6);
    check("gameC_high", 32'(high_score), 32'd6);
    check("gameC_nh", 32'(new_high), 32'd1);
    check("gameC_score_held", 32'(score), 32'd6);
    clear_high = 1'b1; tick(); clear_high = 1'b0;
    check("clear_over_high", 32'(high_score), 32'd0);
    check("clear_over_nh", 32'(new_high), 32'd1);

    // saturation
    p0 = dut_pulses;
    start_game();
    check("restart_nh", 32'(new_high), 32'd0);
    repeat (105) add_point();
    check("sat_score", 32'(score), 32'd99);
    check("sat_pulses", 32'(dut_pulses - p0), 32'd99);
    end_game();
    check("sat_high", 32'(high_score), 32'd99);

    // asynchronous reset mid-game
    start_game();
    repeat (7) add_point();
    check("pre_reset_score", 32'(score), 32'd7);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_score", 32'(score), 32'd0);
    check("async_rst_high", 32'(high_score), 32'd0);
    check("async_rst_nh", 32'(new_high), 32'd0);
    check("async_rst_pulse", 32'(score_pulse), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_game();
    add_point();
    check("post_reset_score", 32'(score), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
